// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the
// external async memory bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic SEL_RAM   = 1'b0;
  localparam logic SEL_FLASH = 1'b1;

  localparam int WAIT_CYCLES_DEF = 3;

endpackage

// File: rtl/mem_bus_rr_arb.sv
// mem_bus_rr_arb: two-port arbiter with a last-grant pointer.
// MEM_BUS_ARB_FAIR_EN selects round-robin, else fixed priority.
module mem_bus_rr_arb
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  // 1 = port 1 was granted most recently
  logic last;

  // track the port that won the last accepted grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take && |gnt) begin
      last <= gnt[1];
    end
  end

`ifdef MEM_BUS_ARB_FAIR_EN
  // round-robin: a tie goes to the port not served last
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last;

  // fixed priority: port 0 always wins a tie
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      req[0]:             gnt = 2'b01;
      (req[1] & ~req[0]): gnt = 2'b10;
      default:            gnt = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-port controller for the shared async RAM/flash
// bus. Define MEM_BUS_ARB_FAIR_EN for round-robin arbitration.
module mem_bus_arb
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = 23
) (
  input  logic              CLK,
  input  logic              RST_SYNC_N,
  input  logic              M0_REQ_IN,
  input  logic [ADDR_W-1:0] M0_ADDR_IN,
  input  logic              M0_WE_IN,
  input  logic [1:0]        M0_BE_IN,
  input  logic              M0_SEL_IN,
  input  logic [15:0]       M0_WDATA_IN,
  input  logic              M1_REQ_IN,
  input  logic [ADDR_W-1:0] M1_ADDR_IN,
  input  logic              M1_WE_IN,
  input  logic [1:0]        M1_BE_IN,
  input  logic              M1_SEL_IN,
  input  logic [15:0]       M1_WDATA_IN,
  output logic              M0_ACK_OUT,
  output logic              M1_ACK_OUT,
  output logic [15:0]       RDATA_OUT,
  output logic [ADDR_W:0]   MEM_ADDR_OUT,
  input  logic [15:0]       MEM_DATA_IN,
  output logic [15:0]       MEM_DATA_OUT,
  output logic              MEM_DATA_OE_OUT,
  output logic              MEM_OE_OUT,
  output logic              MEM_WR_OUT,
  output logic              RAM_CS_OUT,
  output logic              FLASH_CS_OUT,
  output logic              RAM_LB_OUT,
  output logic              RAM_UB_OUT,
  output logic              RAM_ADV_OUT,
  output logic              RAM_CLK_OUT,
  output logic              RAM_CRE_OUT,
  output logic              FLASH_RP_OUT
);

  state_t            state;
  logic [3:0]        cnt;
  logic              gidx;
  logic              we_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              take;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [1:0]        w_be;
  logic              w_sel;
  logic [15:0]       w_wdata;

  assign req  = {M1_REQ_IN, M0_REQ_IN};
  assign take = (state == IDLE);

  assign RAM_ADV_OUT  = 1'b0;
  assign RAM_CLK_OUT  = 1'b0;
  assign RAM_CRE_OUT  = 1'b0;
  assign FLASH_RP_OUT = 1'b1;

  mem_bus_rr_arb u_arb (
    .clk   (CLK),
    .rst_n (RST_SYNC_N),
    .req   (req),
    .take  (take),
    .gnt   (gnt)
  );

  // route the winning requester's fields to the latch
  always_comb begin
    w_addr  = M0_ADDR_IN;
    w_we    = M0_WE_IN;
    w_be    = M0_BE_IN;
    w_sel   = M0_SEL_IN;
    w_wdata = M0_WDATA_IN;
    if (gnt[1]) begin
      w_addr  = M1_ADDR_IN;
      w_we    = M1_WE_IN;
      w_be    = M1_BE_IN;
      w_sel   = M1_SEL_IN;
      w_wdata = M1_WDATA_IN;
    end
  end

  // bus sequencer; every pin is registered so strobes are clean
  always_ff @(posedge CLK) begin
    if (!RST_SYNC_N) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      gidx            <= 1'b0;
      we_q            <= 1'b0;
      M0_ACK_OUT      <= 1'b0;
      M1_ACK_OUT      <= 1'b0;
      RDATA_OUT       <= 16'h0000;
      MEM_ADDR_OUT    <= '0;
      MEM_DATA_OUT    <= 16'h0000;
      MEM_DATA_OE_OUT <= 1'b0;
      MEM_OE_OUT      <= 1'b1;
      MEM_WR_OUT      <= 1'b1;
      RAM_CS_OUT      <= 1'b1;
      FLASH_CS_OUT    <= 1'b1;
      RAM_LB_OUT      <= 1'b1;
      RAM_UB_OUT      <= 1'b1;
    end else begin
      M0_ACK_OUT <= 1'b0;
      M1_ACK_OUT <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            state           <= SETUP;
            gidx            <= gnt[1];
            we_q            <= w_we;
            MEM_ADDR_OUT    <= {w_addr, 1'b0};
            MEM_DATA_OUT    <= w_wdata;
            MEM_DATA_OE_OUT <= w_we;
            RAM_CS_OUT      <= (w_sel != SEL_RAM);
            FLASH_CS_OUT    <= (w_sel != SEL_FLASH);
            RAM_LB_OUT      <= ~w_be[0];
            RAM_UB_OUT      <= ~w_be[1];
          end
        end
        SETUP: begin
          state      <= STROBE;
          cnt        <= 4'(WAIT_CYCLES - 1);
          MEM_OE_OUT <= we_q;
          MEM_WR_OUT <= ~we_q;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state      <= HOLD;
            MEM_OE_OUT <= 1'b1;
            MEM_WR_OUT <= 1'b1;
            M0_ACK_OUT <= ~gidx;
            M1_ACK_OUT <= gidx;
            if (!we_q) begin
              RDATA_OUT <= MEM_DATA_IN;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state           <= IDLE;
          MEM_DATA_OE_OUT <= 1'b0;
          RAM_CS_OUT      <= 1'b1;
          FLASH_CS_OUT    <= 1'b1;
          RAM_LB_OUT      <= 1'b1;
          RAM_UB_OUT      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: bench for mem_bus_arb with a W=3 and a W=1
// instance, a pad-side memory and a transaction-level model.
module tb_mem_bus_arb;

  localparam int AW = 23;

  function automatic int wc(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_n;
  logic chk_en;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic          m0_req[2], m1_req[2];
  logic [AW-1:0] m0_addr[2], m1_addr[2];
  logic          m0_we[2], m1_we[2];
  logic [1:0]    m0_be[2], m1_be[2];
  logic          m0_sel[2], m1_sel[2];
  logic [15:0]   m0_wd[2], m1_wd[2];
  logic          m0_ack[2], m1_ack[2];
  logic [15:0]   rdata[2], mdin[2], mdout[2];
  logic [23:0]   maddr[2];
  logic          doe[2], oe_n[2], wr_n[2];
  logic          rcs[2], fcs[2], lb[2], ub[2];
  logic          adv[2], rclk[2], cre[2], rp[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arb #(
      .WAIT_CYCLES (g == 0 ? 3 : 1),
      .ADDR_W      (AW)
    ) u_dut (
      .CLK             (clk),
      .RST_SYNC_N      (rst_n),
      .M0_REQ_IN       (m0_req[g]),
      .M0_ADDR_IN      (m0_addr[g]),
      .M0_WE_IN        (m0_we[g]),
      .M0_BE_IN        (m0_be[g]),
      .M0_SEL_IN       (m0_sel[g]),
      .M0_WDATA_IN     (m0_wd[g]),
      .M1_REQ_IN       (m1_req[g]),
      .M1_ADDR_IN      (m1_addr[g]),
      .M1_WE_IN        (m1_we[g]),
      .M1_BE_IN        (m1_be[g]),
      .M1_SEL_IN       (m1_sel[g]),
      .M1_WDATA_IN     (m1_wd[g]),
      .M0_ACK_OUT      (m0_ack[g]),
      .M1_ACK_OUT      (m1_ack[g]),
      .RDATA_OUT       (rdata[g]),
      .MEM_ADDR_OUT    (maddr[g]),
      .MEM_DATA_IN     (mdin[g]),
      .MEM_DATA_OUT    (mdout[g]),
      .MEM_DATA_OE_OUT (doe[g]),
      .MEM_OE_OUT      (oe_n[g]),
      .MEM_WR_OUT      (wr_n[g]),
      .RAM_CS_OUT      (rcs[g]),
      .FLASH_CS_OUT    (fcs[g]),
      .RAM_LB_OUT      (lb[g]),
      .RAM_UB_OUT      (ub[g]),
      .RAM_ADV_OUT     (adv[g]),
      .RAM_CLK_OUT     (rclk[g]),
      .RAM_CRE_OUT     (cre[g]),
      .FLASH_RP_OUT    (rp[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memories: pad side (written from pins) and model side
  logic [15:0] pad_mem[int];
  logic [15:0] ref_mem[int];

  function automatic int key(input int i, input logic sel,
                             input logic [AW-1:0] a);
    return (i << 24) | (int'(sel) << 23) | int'(a);
  endfunction

  function automatic logic [15:0] pad_rd(input int kk);
    return pad_mem.exists(kk) ? pad_mem[kk] : 16'hC3C3;
  endfunction

  function automatic logic [15:0] ref_rd(input int kk);
    return ref_mem.exists(kk) ? ref_mem[kk] : 16'hC3C3;
  endfunction

  // pad-side devices: write on strobe, drive data while OE low
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!wr_n[i] && (!rcs[i] || !fcs[i])) begin
        int kk;
        logic [15:0] old;
        kk  = key(i, !fcs[i], maddr[i][23:1]);
        old = pad_rd(kk);
        pad_mem[kk] = {!ub[i] ? mdout[i][15:8] : old[15:8],
                       !lb[i] ? mdout[i][7:0]  : old[7:0]};
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!oe_n[i] && (!rcs[i] || !fcs[i]))
        mdin[i] = pad_rd(key(i, !fcs[i], maddr[i][23:1]));
      else
        mdin[i] = 16'hDEAD;
    end
  end

  // transaction model: one access at a time, phase = cycle offset
  bit            busy[2], fresh[2];
  int            k[2];
  logic          gp[2], lastg[2];
  logic [AW-1:0] t_addr[2];
  logic          t_we[2], t_sel[2];
  logic [1:0]    t_be[2];
  logic [15:0]   t_wd[2], rd[2], e_dout[2];
  logic [23:0]   e_addr[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        busy[i]   = 0;
        fresh[i]  = 1;
        k[i]      = 0;
        rd[i]     = 16'h0;
        e_addr[i] = 24'h0;
        e_dout[i] = 16'h0;
        lastg[i]  = 1'b1;
      end else if (busy[i]) begin
        k[i]++;
        if (k[i] == wc(i) + 1) begin
          int kk;
          logic [15:0] old;
          kk = key(i, t_sel[i], t_addr[i]);
          if (t_we[i]) begin
            old = ref_rd(kk);
            ref_mem[kk] = {t_be[i][1] ? t_wd[i][15:8] : old[15:8],
                           t_be[i][0] ? t_wd[i][7:0]  : old[7:0]};
          end else begin
            rd[i] = ref_rd(kk);
          end
        end else if (k[i] == wc(i) + 2) begin
          busy[i] = 0;
        end
      end else if (m0_req[i] || m1_req[i]) begin
`ifdef MEM_BUS_ARB_FAIR_EN
        gp[i] = (m0_req[i] && m1_req[i]) ? !lastg[i] : m1_req[i];
`else
        gp[i] = !m0_req[i];
`endif
        lastg[i]  = gp[i];
        t_addr[i] = gp[i] ? m1_addr[i] : m0_addr[i];
        t_we[i]   = gp[i] ? m1_we[i]   : m0_we[i];
        t_be[i]   = gp[i] ? m1_be[i]   : m0_be[i];
        t_sel[i]  = gp[i] ? m1_sel[i]  : m0_sel[i];
        t_wd[i]   = gp[i] ? m1_wd[i]   : m0_wd[i];
        e_addr[i] = {t_addr[i], 1'b0};
        e_dout[i] = t_wd[i];
        busy[i]   = 1;
        fresh[i]  = 0;
        k[i]      = 0;
      end
    end
  end

  // compare every output against the model each cycle
  bit          st, hd;
  logic [28:0] e_ctl, a_ctl;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        st = busy[i] && k[i] >= 1 && k[i] <= wc(i);
        hd = busy[i] && k[i] == wc(i) + 1;
        e_ctl = {hd && !gp[i], hd && gp[i],
                 !(st && !t_we[i]), !(st && t_we[i]),
                 !(busy[i] && !t_sel[i]), !(busy[i] && t_sel[i]),
                 !(busy[i] && t_be[i][0]), !(busy[i] && t_be[i][1]),
                 busy[i] && t_we[i], rd[i], 4'b0001};
        a_ctl = {m0_ack[i], m1_ack[i], oe_n[i], wr_n[i],
                 rcs[i], fcs[i], lb[i], ub[i], doe[i], rdata[i],
                 adv[i], rclk[i], cre[i], rp[i]};
        chk(i == 0 ? "ctl_w3" : "ctl_w1", 64'(a_ctl), 64'(e_ctl));
        if (busy[i] || fresh[i])
          chk(i == 0 ? "addr_w3" : "addr_w1", 64'(maddr[i]),
              64'(e_addr[i]));
        if ((busy[i] && t_we[i]) || fresh[i])
          chk(i == 0 ? "dout_w3" : "dout_w1", 64'(mdout[i]),
              64'(e_dout[i]));
      end
    end
  end

  // one requester access from IDLE; returns phase observations
  task automatic access(
    input  int            i,
    input  bit            p,
    input  logic [AW-1:0] a,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic          sel,
    input  logic [15:0]   wd,
    input  bit            drop,
    input  string         nm,
    output int            oc,
    output int            wcn,
    output int            dc,
    output logic [23:0]   as,
    output logic [3:0]    cl
  );
    int lat;
    lat = 0; oc = 0; wcn = 0; dc = 0; as = '0; cl = '0;
    if (p) begin
      m1_addr[i] = a; m1_we[i] = we; m1_be[i] = be;
      m1_sel[i] = sel; m1_wd[i] = wd; m1_req[i] = 1'b1;
    end else begin
      m0_addr[i] = a; m0_we[i] = we; m0_be[i] = be;
      m0_sel[i] = sel; m0_wd[i] = wd; m0_req[i] = 1'b1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        as = maddr[i];
        cl = {rcs[i], fcs[i], lb[i], ub[i]};
        if (drop) begin
          m0_req[i] = 1'b0;
          m1_req[i] = 1'b0;
        end
      end
      oc  += int'(!oe_n[i]);
      wcn += int'(!wr_n[i]);
      dc  += int'(doe[i]);
      if ((p ? m1_ack[i] : m0_ack[i]) === 1'b1) begin
        lat = n;
        break;
      end
    end
    m0_req[i] = 1'b0;
    m1_req[i] = 1'b0;
    chk({nm, "_lat"}, lat, wc(i) + 2);
    @(posedge clk); #1;
  endtask

  initial begin
    int oc, wcn, dc, n, bad, o;
    logic [23:0] as;
    logic [3:0] cl;
    int ord[$];
    int tk[$];

    rst_n  = 1'b0;
    chk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m0_req[i] = 0; m0_addr[i] = '0; m0_we[i] = 0; m0_be[i] = 0;
      m0_sel[i] = 0; m0_wd[i] = 0;
      m1_req[i] = 0; m1_addr[i] = '0; m1_we[i] = 0; m1_be[i] = 0;
      m1_sel[i] = 0; m1_wd[i] = 0;
      mdin[i] = 16'hDEAD;
    end
    pad_mem[key(0, 1'b0, 23'h12345)] = 16'hBEEF;
    ref_mem[key(0, 1'b0, 23'h12345)] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_strobes", {rcs[0], fcs[0], oe_n[0], wr_n[0], lb[0], ub[0]},
        6'h3F);
    chk("rst_doe_ack", {doe[0], m0_ack[0], m1_ack[0]}, 3'b000);
    chk("rst_rdata", rdata[0], 16'h0000);
    chk("rst_addr", maddr[0], 24'h000000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(0, 1, 23'h12345, 0, 2'b11, 0, 16'h0, 0, "m1_rd",
           oc, wcn, dc, as, cl);
    chk("m1_rd_addr", as, 24'h02468A);
    chk("m1_rd_oe", oc, 3);
    chk("m1_rd_wr", wcn, 0);
    chk("m1_rd_cs", cl, 4'b0100);
    chk("m1_rd_data", rdata[0], 16'hBEEF);
    chk("model_rd", rd[0], 16'hBEEF);

    access(0, 0, 23'h000555, 1, 2'b01, 1, 16'h00AA, 0, "m0_wr",
           oc, wcn, dc, as, cl);
    chk("m0_wr_addr", as, 24'h000AAA);
    chk("m0_wr_wr", wcn, 3);
    chk("m0_wr_oe", oc, 0);
    chk("m0_wr_doe", dc, 5);
    chk("m0_wr_cs", cl, 4'b1001);
    chk("m0_wr_keep", rdata[0], 16'hBEEF);

    access(0, 1, 23'h000555, 0, 2'b11, 1, 16'h0, 0, "fl_rd",
           oc, wcn, dc, as, cl);
    chk("fl_rd_data", rdata[0], 16'hC3AA);

    access(0, 1, 23'h12345, 1, 2'b00, 0, 16'h5555, 1, "be0_wr",
           oc, wcn, dc, as, cl);
    chk("be0_wr_cs", cl, 4'b0111);
    chk("be0_wr_wr", wcn, 3);

    access(0, 0, 23'h12345, 0, 2'b10, 0, 16'h0, 0, "be0_rd",
           oc, wcn, dc, as, cl);
    chk("be0_rd_data", rdata[0], 16'hBEEF);

    m0_addr[0] = 23'h12345; m0_we[0] = 0; m0_be[0] = 2'b11;
    m0_sel[0] = 0; m0_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_oe", oe_n[0], 1'b0);
    rst_n = 1'b0;
    m0_req[0] = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!oe_n[0] || !wr_n[0] || m0_ack[0] || !rcs[0] || doe[0])
        bad++;
    end
    chk("rst_mid", bad, 0);
    chk("rst_mid_rdata", rdata[0], 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    m0_addr[0] = 23'h100; m0_we[0] = 0; m0_be[0] = 2'b11; m0_sel[0] = 0;
    m1_addr[0] = 23'h200; m1_we[0] = 0; m1_be[0] = 2'b11; m1_sel[0] = 0;
    m0_req[0] = 1'b1;
    m1_req[0] = 1'b1;
    n = 0;
    while (ord.size() < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (m0_ack[0]) begin ord.push_back(0); tk.push_back(n); end
      if (m1_ack[0]) begin ord.push_back(1); tk.push_back(n); end
    end
    m0_req[0] = 1'b0;
    m1_req[0] = 1'b0;
    chk("tie_count", ord.size(), 3);
    if (ord.size() == 3) begin
      o = ord[0] * 4 + ord[1] * 2 + ord[2];
`ifdef MEM_BUS_ARB_FAIR_EN
      chk("tie_order", o, 2);
`else
      chk("tie_order", o, 0);
`endif
      chk("tie_first_lat", tk[0], 5);
      chk("b2b_period", tk[1] - tk[0], 6);
    end
    @(posedge clk); #1;

    access(1, 0, 23'h00100, 1, 2'b11, 0, 16'h1234, 0, "w1_wr",
           oc, wcn, dc, as, cl);
    chk("w1_wr_wr", wcn, 1);
    chk("w1_wr_doe", dc, 3);
    access(1, 1, 23'h00100, 0, 2'b11, 0, 16'h0, 0, "w1_rd",
           oc, wcn, dc, as, cl);
    chk("w1_rd_oe", oc, 1);
    chk("w1_rd_data", rdata[1], 16'h1234);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
